neg_pulse_train_gen: RTL and testbench
======================================

Name: neg_pulse_train_gen

Overview:
- Generates clean, glitch-free trains of active-low pulses on a single output line `sig`.
- Each burst is requested by a one-cycle `start` strobe carrying the pulse count, low width and high gap.
- It is the stimulus/transmit side for our negative-edge detectors: every falling edge on `sig` is exactly one intended event.
- Used to drive strobe/select lines and to self-test edge-detect paths in-system.

Parameters:
- CNT_W, 8, width of the n_pulses / low_cyc / high_cyc fields and internal counters.
- IDLE_LVL, 1, level of `sig` in reset and IDLE; pulses drive the opposite level.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle burst request; sampled only in IDLE.
- n_pulses  in  CNT_W  number of low pulses in the burst; latched on accepted start.
- low_cyc  in  CNT_W  low width in clocks; latched; 0 treated as 1.
- high_cyc  in  CNT_W  high gap after each pulse in clocks; latched; 0 treated as 1.
- abort  in  1  synchronous burst cancel.
- sig  out  1  pulse output; registered, no combinational path from inputs.
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle strobe at normal burst completion.
- pulse_cnt  out  CNT_W  pulses fully emitted in the current or last burst.

Behaviour:
- Reset (async assert, sync release): sig=IDLE_LVL, busy=0, done=0, pulse_cnt=0, state=IDLE, all counters 0.
- States: IDLE, LOW, HIGH, FIN.
- IDLE:
  - start=1 with n_pulses!=0: latch params, go to LOW, clear pulse_cnt. At the next edge sig=~IDLE_LVL and busy=1, so the first falling edge lags start by 1 cycle.
  - start=1 with n_pulses==0: go to FIN, clear pulse_cnt, sig does not move. done=1 for the following cycle.
  - All other inputs ignored.
- LOW:
  - sig=~IDLE_LVL for exactly max(low_cyc,1) cycles.
  - Then sig=IDLE_LVL, pulse_cnt increments in the same cycle, go to HIGH.
- HIGH:
  - sig=IDLE_LVL for exactly max(high_cyc,1) cycles, including after the last pulse (trailing gap guaranteed).
  - Then: if pulse_cnt < latched n_pulses, go to LOW; else go to FIN.
- FIN: one cycle with done=1 and busy=0; return to IDLE. done and busy are never high together.
- Back-to-back bursts: start is accepted in the cycle after FIN (IDLE). Minimum spacing between bursts = trailing gap + 1 cycle.
- start while busy or in FIN: ignored and not queued. Latched parameters never change mid-burst.
- abort=1 in LOW or HIGH:
  - Next edge: sig=IDLE_LVL, busy=0, state=IDLE, done stays 0, pulse_cnt holds the completed-pulse count.
  - A pulse cut short is not counted.
- abort in IDLE or FIN: no effect; a FIN done strobe still occurs.
- abort and start together in IDLE: abort wins and start is dropped.
- Reset mid-burst: sig returns to IDLE_LVL asynchronously. No done is produced.
- Counters: width CNT_W, load latched value, count down to 1. Maximum widths are 2^CNT_W-1 cycles with no wrap; pulse_cnt saturation is not needed because it is bounded by n_pulses.
- sig toggles only on clock edges. There is exactly one falling edge per pulse and no runt pulses, including at abort.

Test Plan:
- Reset hold: rst_n=0 for 3 cycles, inputs random → sig=1, busy=0, done=0, pulse_cnt=0 throughout. Release → still idle.
- Single burst: start at cycle 10 with n=3, low=2, high=4.
  - Required sig (high=1): low at cycles 11-12, 17-18, 23-24; high from 25.
  - done=1 at cycle 29 only; busy=1 for cycles 11-28; pulse_cnt=3.
- Zero/degenerate: n=0 → done at +1 cycle, sig never low. n=2, low=0, high=0 → 1-cycle low pulses separated by 1 high cycle, done 4 cycles after the first low.
- Ignore while busy: start with n=5 during a burst of n=2 → exactly 2 falling edges, latched params unchanged. A new start the cycle after done is accepted.
- Abort: n=4, low=3, high=3, abort during the 2nd low cycle of pulse 2 → sig=1 next cycle, busy=0, done never asserted, pulse_cnt=1, no further edges.
- Async reset mid-LOW: rst_n falls between clock edges → sig=1 immediately, without waiting for a clock edge. After release the block is idle, and a fresh start with n=1 yields one pulse.

Source files
------------

// File: rtl/neg_pulse_train_gen_if.sv
// Request/status bundle for the active-low pulse train generator.
// The master issues bursts; the slave (the generator) drives the pulse line and status.
interface neg_pulse_train_gen_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] n_pulses;
  logic [CNT_W-1:0] low_cyc;
  logic [CNT_W-1:0] high_cyc;
  logic             abort;
  logic             sig;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulse_cnt;

  modport master (
    output start, n_pulses, low_cyc, high_cyc, abort,
    input  sig, busy, done, pulse_cnt
  );

  modport slave (
    input  start, n_pulses, low_cyc, high_cyc, abort,
    output sig, busy, done, pulse_cnt
  );
endinterface

// File: rtl/neg_pulse_train_gen.sv
// Emits bursts of active-low pulses with programmable count, low width and high gap.
// All outputs are registered so the pulse line only ever moves on a clock edge.
module neg_pulse_train_gen #(
  parameter int unsigned CNT_W    = 8,
  parameter bit          IDLE_LVL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  neg_pulse_train_gen_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StFin} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             sig_q, sig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      n_q     <= '0;
      low_q   <= '0;
      high_q  <= '0;
      pcnt_q  <= '0;
      sig_q   <= IDLE_LVL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      low_q   <= low_d;
      high_q  <= high_d;
      pcnt_q  <= pcnt_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    low_d   = low_q;
    high_d  = high_q;
    pcnt_d  = pcnt_q;
    unique case (state_q)
      StIdle: begin
        // abort beats a simultaneous start
        if (bus.start && !bus.abort) begin
          n_d    = bus.n_pulses;
          low_d  = at_least_one(bus.low_cyc);
          high_d = at_least_one(bus.high_cyc);
          pcnt_d = '0;
          if (bus.n_pulses != '0) begin
            state_d = StLow;
            cnt_d   = at_least_one(bus.low_cyc);
          end else begin
            state_d = StFin;
          end
        end
      end
      StLow: begin
        if (bus.abort) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = StHigh;
          cnt_d   = high_q;
          pcnt_d  = pcnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHigh: begin
        if (bus.abort) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          if (pcnt_q < n_q) begin
            state_d = StLow;
            cnt_d   = low_q;
          end else begin
            state_d = StFin;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they never glitch.
  always_comb begin
    sig_d  = (state_d == StLow) ? ~IDLE_LVL : IDLE_LVL;
    busy_d = (state_d == StLow) || (state_d == StHigh);
    done_d = (state_d == StFin);
  end

  assign bus.sig       = sig_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pulse_cnt = pcnt_q;

endmodule

// File: tb/tb_neg_pulse_train_gen.sv
// Bench for neg_pulse_train_gen: each burst pushes its expected per-cycle waveform to a
// queue, which is popped and compared cycle by cycle as the generator runs.
module tb_neg_pulse_train_gen;

  localparam int CNT_W = 8;
  localparam int EW    = CNT_W + 3;

  typedef logic [EW-1:0] ent_t;  // {sig, busy, done, pulse_cnt}

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  neg_pulse_train_gen_if #(.CNT_W(CNT_W)) bus ();

  neg_pulse_train_gen #(
    .CNT_W    (CNT_W),
    .IDLE_LVL (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  ent_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    exp_pcnt = 0;
  int    cyc_idx = 0;
  string cur_tag = "init";

  function automatic ent_t mk(input bit s, input bit b, input bit d, input int p);
    return {s, b, d, CNT_W'(p)};
  endfunction

  function automatic ent_t obs();
    return {bus.sig, bus.busy, bus.done, bus.pulse_cnt};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Advance one cycle and sample on the falling edge.
  task automatic step();
    ent_t e;
    @(posedge clk);
    @(negedge clk);
    cyc_idx++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq($sformatf("%s cyc%0d {sig,busy,done,pcnt}", cur_tag, cyc_idx), 32'(obs()),
               32'(e));
    end
  endtask

  task automatic scramble();
    bus.n_pulses = CNT_W'($urandom);
    bus.low_cyc  = CNT_W'($urandom);
    bus.high_cyc = CNT_W'($urandom);
  endtask

  task automatic idle(input string tag, input int k);
    cur_tag = tag;
    cyc_idx = 0;
    for (int i = 0; i < k; i++) begin
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, exp_pcnt));
      step();
      bus.start = 1'b0;
      bus.abort = 1'b0;
    end
  endtask

  // abort_after: cycles of burst before abort lands (0 = none); inj_at: stray start cycle.
  task automatic burst(input string tag, input int n, input int lo, input int hi,
                       input int abort_after, input int inj_at);
    ent_t full[$];
    ent_t last;
    int   lo_e;
    int   hi_e;
    lo_e = (lo == 0) ? 1 : lo;
    hi_e = (hi == 0) ? 1 : hi;
    for (int p = 0; p < n; p++) begin
      for (int j = 0; j < lo_e; j++) full.push_back(mk(1'b0, 1'b1, 1'b0, p));
      for (int j = 0; j < hi_e; j++) full.push_back(mk(1'b1, 1'b1, 1'b0, p + 1));
    end
    if (abort_after > 0 && abort_after < full.size()) begin
      while (full.size() > abort_after) void'(full.pop_back());
      last     = full[full.size()-1];
      exp_pcnt = int'(last[CNT_W-1:0]);
      full.push_back(mk(1'b1, 1'b0, 1'b0, exp_pcnt));
    end else begin
      exp_pcnt = n;
      full.push_back(mk(1'b1, 1'b0, 1'b1, n));
      full.push_back(mk(1'b1, 1'b0, 1'b0, n));
    end
    foreach (full[i]) exp_q.push_back(full[i]);
    cur_tag      = tag;
    cyc_idx      = 0;
    bus.start    = 1'b1;
    bus.n_pulses = CNT_W'(n);
    bus.low_cyc  = CNT_W'(lo);
    bus.high_cyc = CNT_W'(hi);
    for (int i = 1; i <= full.size(); i++) begin
      step();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      scramble();
      if (i == abort_after) bus.abort = 1'b1;
      if (i == inj_at) begin
        bus.start    = 1'b1;
        bus.n_pulses = CNT_W'(5);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    scramble();

    // Reset hold with random inputs
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'($urandom);
      bus.abort = 1'($urandom);
      scramble();
      @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("reset_hold%0d", i), 32'(obs()), 32'(mk(1'b1, 1'b0, 1'b0, 0)));
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst_n     = 1'b1;
    idle("post_reset", 10);

    burst("single", 3, 2, 4, 0, 0);
    idle("gap1", 2);
    burst("n_zero", 0, 5, 5, 0, 0);
    burst("degenerate", 2, 0, 0, 0, 0);
    burst("ignore_busy", 2, 1, 2, 0, 2);
    // Back-to-back: accepted in the cycle right after done
    burst("back_to_back", 1, 2, 1, 0, 0);
    burst("abort", 4, 3, 3, 8, 0);
    idle("after_abort", 4);

    bus.start    = 1'b1;
    bus.abort    = 1'b1;
    bus.n_pulses = CNT_W'(3);
    idle("abort_and_start", 4);

    // Asynchronous reset while the line is low
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 0));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 0));
    cur_tag      = "pre_async";
    cyc_idx      = 0;
    bus.start    = 1'b1;
    bus.n_pulses = CNT_W'(3);
    bus.low_cyc  = CNT_W'(4);
    bus.high_cyc = CNT_W'(2);
    step();
    bus.start = 1'b0;
    step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset", 32'(obs()), 32'(mk(1'b1, 1'b0, 1'b0, 0)));
    exp_q.delete();
    @(negedge clk);
    rst_n    = 1'b1;
    exp_pcnt = 0;
    idle("post_async", 2);
    burst("fresh_single", 1, 1, 1, 0, 0);

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
